// File: rtl/neural_mac_seq_ctrl.sv
// neural_mac_seq_ctrl: sequencer between a PIO mailbox and a pipelined dot-product engine.
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   hw_req_i       in   SW->HW word request (4-phase)
//   hw_data_i      in   SW->HW word; command {op[31:28], N[15:0]} or data [15:0]
//   sw_ack_o       out  HW->SW acknowledge
//   sw_data_o      out  scaled, saturated dot-product result
//   cfg_i          in   [4:0] result right-shift, [8] ReLU enable (latched at RUN)
//   status_o       out  [0] busy [1] done [2] err [3] wvalid [31:16] loaded count
module neural_mac_seq_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        hw_req_i,
    input  logic [31:0] hw_data_i,
    output logic        sw_ack_o,
    output logic [31:0] sw_data_o,
    input  logic [31:0] cfg_i,
    output logic [31:0] status_o
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_POST, S_DONE} state_t;
    localparam logic [15:0] L_DEPTH = 16'(DEPTH);
    localparam logic signed [ACC_W-1:0] L_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] L_MIN = {{(ACC_W-31){1'b1}}, 31'd0};
    state_t r_state, w_next;
    logic r_ack, r_pend, r_busy, r_done, r_err, r_wvalid, r_relu, r_v1, r_v2;
    logic [3:0] r_op;
    logic [15:0] r_cmd_n, r_n, r_loaded, r_idx;
    logic [4:0] r_shift;
    logic [15:0] r_ram [DEPTH];
    logic signed [15:0] r_w, r_x;
    logic signed [31:0] r_p;
    logic signed [ACC_W-1:0] r_acc, w_sh, w_rl;
    logic [31:0] r_out, w_sat;
    logic w_cap, w_last, w_load_ok, w_run_ok, w_unused;
    // A word is taken only on a fresh request, never while acked or decoding a command
    assign w_cap = hw_req_i && !r_ack && !r_pend &&
                   (r_state == S_IDLE || r_state == S_LOAD || r_state == S_RUN);
    assign w_last = r_idx == r_n - 16'd1;
    assign w_load_ok = r_pend && r_op == 4'd1 && r_cmd_n != 16'd0 && r_cmd_n <= L_DEPTH;
    assign w_run_ok = r_pend && r_op == 4'd2 && r_cmd_n != 16'd0 && r_cmd_n <= r_loaded;
    assign w_unused = ^{cfg_i[31:9], cfg_i[7:5], hw_data_i[27:16]};
    assign sw_ack_o = r_ack;
    assign sw_data_o = r_out;
    assign status_o = {r_loaded, 12'd0, r_wvalid, r_err, r_done, r_busy};
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_load_ok ? S_LOAD : w_run_ok ? S_RUN : S_IDLE;
            S_LOAD:  w_next = (w_cap && w_last) ? S_IDLE : S_LOAD;
            S_RUN:   w_next = (w_cap && w_last) ? S_DRAIN : S_RUN;
            S_DRAIN: w_next = (r_v1 || r_v2) ? S_DRAIN : S_POST;
            S_POST:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end
    always_comb begin
        w_sh = r_acc >>> r_shift;
        w_rl = (r_relu && w_sh[ACC_W-1]) ? '0 : w_sh;
        w_sat = (w_rl > L_MAX) ? 32'h7FFF_FFFF : (w_rl < L_MIN) ? 32'h8000_0000 : w_rl[31:0];
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk_clk) begin
        if (r_state == S_LOAD && w_cap) r_ram[r_idx[ADDR_W-1:0]] <= hw_data_i[15:0];
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ack <= 1'b0;
            r_pend <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err <= 1'b0;
            r_wvalid <= 1'b0;
            r_relu <= 1'b0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_op <= '0;
            r_cmd_n <= '0;
            r_n <= '0;
            r_loaded <= '0;
            r_idx <= '0;
            r_shift <= '0;
            r_w <= '0;
            r_x <= '0;
            r_p <= '0;
            r_acc <= '0;
            r_out <= '0;
        end else begin
            // Ack rises after a capture and falls the cycle after req is seen low
            r_ack <= w_cap || (r_ack && hw_req_i);
            r_pend <= w_cap && r_state == S_IDLE;
            if (w_cap && r_state == S_IDLE) begin
                r_op <= hw_data_i[31:28];
                r_cmd_n <= hw_data_i[15:0];
            end
            if (r_pend && (r_op == 4'd1 || r_op == 4'd2 || r_op == 4'd3)) begin
                r_done <= 1'b0;
                r_err <= (r_op == 4'd1 && !w_load_ok) || (r_op == 4'd2 && !w_run_ok);
                r_busy <= w_load_ok || w_run_ok;
                r_n <= r_cmd_n;
                r_idx <= '0;
            end
            if (w_load_ok || (r_pend && r_op == 4'd3)) begin
                r_loaded <= '0;
                r_wvalid <= 1'b0;
            end
            if (w_run_ok) begin
                r_shift <= cfg_i[4:0];
                r_relu <= cfg_i[8];
                r_acc <= '0;
            end
            if (w_cap && (r_state == S_LOAD || r_state == S_RUN)) r_idx <= r_idx + 16'd1;
            if (w_cap && r_state == S_LOAD && w_last) begin
                r_loaded <= r_n;
                r_wvalid <= 1'b1;
                r_busy <= 1'b0;
            end
            // Three-stage MAC: fetch weight/input, multiply, accumulate
            r_v1 <= w_cap && r_state == S_RUN;
            if (w_cap && r_state == S_RUN) begin
                r_w <= r_ram[r_idx[ADDR_W-1:0]];
                r_x <= hw_data_i[15:0];
            end
            r_v2 <= r_v1;
            r_p <= r_w * r_x;
            if (r_v2) r_acc <= r_acc + ACC_W'(r_p);
            if (r_state == S_POST) begin
                r_out <= w_sat;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_neural_mac_seq_ctrl.sv
// tb_neural_mac_seq_ctrl: randomized and directed stimulus for neural_mac_seq_ctrl; results are
// predicted by a plain-arithmetic dot-product model, queued, and checked by a done-edge monitor.
module tb_neural_mac_seq_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, hw_req = 1'b0, sw_ack;
    logic [31:0] hw_data = '0, sw_data, cfg = '0, status;
    int n_cmp = 0, n_bad = 0, ack_rises = 0, loaded_m = 0;
    logic ack_q = 1'b0, done_q = 1'b0;
    logic [31:0] last_out = '0;
    logic signed [15:0] wm [256];
    typedef struct { logic [31:0] data; logic [15:0] loaded; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    neural_mac_seq_ctrl dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .hw_req_i(hw_req), .hw_data_i(hw_data),
        .sw_ack_o(sw_ack), .sw_data_o(sw_data), .cfg_i(cfg), .status_o(status)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sw_ack && !ack_q) ack_rises++;
        ack_q = sw_ack;
        if (status[1] && !done_q) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got result %0h with no pending RUN", sw_data);
            end else begin
                e = sb.pop_front();
                chk("result", sw_data, e.data);
                chk("loaded_at_done", status[31:16], e.loaded);
                chk("busy_at_done", status[0], 0);
            end
        end
        done_q = status[1];
    end

    task automatic send(input logic [31:0] d);
        int t;
        @(posedge clk); #1;
        hw_data = d;
        hw_req = 1'b1;
        t = 0;
        while (!sw_ack && t < 40) begin @(posedge clk); #1; t++; end
        chk("ack_rise", sw_ack, 1);
        hw_req = 1'b0;
        t = 0;
        while (sw_ack && t < 40) begin @(posedge clk); #1; t++; end
        chk("ack_fall", sw_ack, 0);
    endtask

    task automatic send_held(input logic [31:0] d, input int hold);
        int r0;
        r0 = ack_rises;
        @(posedge clk); #1;
        hw_data = d;
        hw_req = 1'b1;
        repeat (hold) @(posedge clk);
        #1 hw_req = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("held_one_ack", 64'(ack_rises - r0), 1);
        chk("held_ack_low", sw_ack, 0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!status[1] && t < 40) begin @(posedge clk); #1; t++; end
        chk("done_seen", status[1], 1);
    endtask

    task automatic do_load(input logic [15:0] ws[$]);
        send({4'd1, 12'd0, 16'(ws.size())});
        foreach (ws[i]) begin
            send({16'($urandom), ws[i]});
            wm[i] = ws[i];
        end
        loaded_m = ws.size();
        repeat (2) @(posedge clk);
        #1 chk("load_wvalid", status[3], 1);
        chk("load_count", status[31:16], 64'(loaded_m));
        chk("load_busy", status[0], 0);
    endtask

    task automatic do_run(input int n, input int sh, input bit relu, input logic [15:0] xs[$]);
        longint s, r;
        exp_t e;
        s = 0;
        for (int i = 0; i < n; i++) s += longint'(wm[i]) * longint'($signed(xs[i]));
        r = s >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        e.data = r[31:0];
        e.loaded = 16'(loaded_m);
        last_out = e.data;
        sb.push_back(e);
        cfg = {23'd0, relu, 3'd0, 5'(sh)};
        send({4'd2, 12'd0, 16'(n)});
        for (int i = 0; i < n; i++) send({16'($urandom), xs[i]});
        wait_done();
    endtask

    task automatic expect_err(input logic [31:0] cmd);
        send(cmd);
        repeat (2) @(posedge clk);
        #1 chk("err_flag", status[2], 1);
        chk("err_busy", status[0], 0);
        chk("err_done_clr", status[1], 0);
        chk("err_data_hold", sw_data, last_out);
    endtask

    initial begin
        logic [15:0] q[$], x[$];
        int n, m;
        repeat (3) @(posedge clk);
        #1 chk("rst_status", status, 0);
        chk("rst_ack", sw_ack, 0);
        chk("rst_data", sw_data, 0);
        rst_n = 1'b1;
        send_held({4'd3, 28'd0}, 6);
        chk("clear_status", status, 0);
        q = '{16'd2, 16'hFFFD, 16'd4};
        do_load(q);
        x = '{16'd5, 16'd6, 16'd7};
        do_run(3, 0, 1'b0, x);
        do_run(3, 1, 1'b0, x);
        q = '{16'd2, 16'd3, 16'd4};
        do_load(q);
        x = '{16'hFFFB, 16'd6, 16'd7};
        do_run(3, 0, 1'b1, x);
        do_run(3, 0, 1'b0, '{16'hFFFB, 16'hFFFA, 16'hFFF9});
        do_run(3, 0, 1'b1, '{16'hFFFB, 16'hFFFA, 16'hFFF9});
        q = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        do_load(q);
        do_run(4, 0, 1'b0, q);
        x = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        do_run(4, 0, 1'b0, x);
        do_run(4, 2, 1'b0, x);
        q = '{16'd2, 16'hFFFD, 16'd4};
        do_load(q);
        expect_err({4'd2, 12'd0, 16'd5});
        expect_err({4'd1, 12'd0, 16'd0});
        expect_err({4'd1, 12'd0, 16'd257});
        // A request held high while LOAD finishes must not be re-captured as a command
        send({4'd1, 12'd0, 16'd1});
        send_held({16'd0, 16'd7}, 8);
        wm[0] = 16'sd7;
        loaded_m = 1;
        chk("held_wvalid", status[3], 1);
        chk("held_loaded", status[31:16], 1);
        chk("held_err", status[2], 0);
        do_run(1, 0, 1'b0, '{16'd3});
        for (int it = 0; it < 8; it++) begin
            n = (it == 7) ? 256 : int'($urandom_range(12, 1));
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(16'($urandom));
            do_load(q);
            for (int r = 0; r < 2; r++) begin
                m = (it == 7 && r == 0) ? n : int'($urandom_range(n, 1));
                x.delete();
                for (int i = 0; i < m; i++) x.push_back(16'($urandom));
                do_run(m, int'($urandom_range(20, 0)), 1'($urandom), x);
            end
        end
        send({4'd1, 12'd0, 16'd4});
        send({16'd0, 16'd1});
        send({16'd0, 16'd2});
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2 chk("midrst_status", status, 0);
        chk("midrst_ack", sw_ack, 0);
        chk("midrst_data", sw_data, 0);
        loaded_m = 0;
        last_out = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q = '{16'd9, 16'd8};
        do_load(q);
        send({4'd3, 28'd0});
        repeat (2) @(posedge clk);
        #1 chk("clr_loaded", status[31:16], 0);
        chk("clr_wvalid", status[3], 0);
        loaded_m = 0;
        expect_err({4'd2, 12'd0, 16'd1});
        repeat (5) @(posedge clk);
        #1 chk("sb_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
